mips_probe_trace: RTL and testbench

- Parametrised on-chip trace buffer for the MIPS core's observable output bus (the 16-bit `out` word, or any other probe).
- Samples the probe each clock and captures timestamped entries into a first-word-fall-through FIFO.
- Capture is either on value change or on an explicit strobe.
- Entries drain through a valid/ready read port, so benches and debug logic can reconstruct execution without waveform dumps.

---
 rtl/mips_probe_trace.sv | 119 +++++++++++
 tb/tb_mips_probe_trace.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mips_probe_trace.sv
// Timestamped trace buffer: captures a probe bus on change or on strobe into a
// first-word-fall-through FIFO drained through a valid/ready port.
module mips_probe_trace #(
  parameter int DATA_W = 16,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     mode,
  input  logic                     strobe,
  input  logic [DATA_W-1:0]        probe,
  input  logic                     clear,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [TS_W+DATA_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TS_W + DATA_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0]     mem_q [DEPTH];
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              first_q, first_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic hit, full, pop, push_ok, drop;

  assign hit     = en && (mode ? strobe : (first_q || (probe != last_q)));
  assign full    = (count_q == FULL_CNT);
  assign pop     = rd_valid && rd_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = hit && (!full || pop);
  assign drop    = hit && full && !pop;

  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_d     = last_q;
    first_d    = first_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    if (en) begin
      last_d  = probe;
      first_d = 1'b0;
    end

    if (clear) begin
      ts_d       = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      first_d    = 1'b1;
      overflow_d = 1'b0;
      drop_d     = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
      first_q    <= 1'b1;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
      first_q    <= first_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[wr_ptr_q] <= {ts_q, probe};
  end

  assign rd_valid = (count_q != '0);
  // Masked so the head reads as zero whenever the FIFO is empty, including reset.
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_mips_probe_trace.sv
// Directed bench for mips_probe_trace: a default instance plus a TS_W=4
// instance sharing the same stimulus for the timestamp wrap scenario.
module tb_mips_probe_trace;

  logic        clk = 1'b0;
  logic        reset, en, mode, strobe, clear, rd_ready;
  logic [15:0] probe;

  logic        rd_valid, overflow;
  logic [31:0] rd_data;
  logic [4:0]  count;
  logic [7:0]  drop_cnt;

  logic        rd_valid4, overflow4;
  logic [19:0] rd_data4;
  logic [4:0]  count4;
  logic [7:0]  drop_cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_probe_trace u_dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .strobe(strobe),
    .probe(probe), .clear(clear), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  mips_probe_trace #(.TS_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .strobe(strobe),
    .probe(probe), .clear(clear), .rd_valid(rd_valid4), .rd_ready(rd_ready),
    .rd_data(rd_data4), .count(count4), .overflow(overflow4), .drop_cnt(drop_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; mode = 1'b0; strobe = 1'b0;
    clear = 1'b0; rd_ready = 1'b0; probe = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_hold();
    do_reset();
    en = 1'b1; mode = 1'b0; probe = 16'h1234;
    for (int i = 0; i < 5; i++) tick();
    total++; if (count !== 5'd1) begin bad++; $display("FAIL hold_count got=%0d exp=1", count); end
    total++; if (rd_data !== {16'd0, 16'h1234}) begin bad++; $display("FAIL hold_data got=%h exp=00001234", rd_data); end
    $display("test_hold done: count=%0d head=%h", count, rd_data);
  endtask

  task automatic test_change();
    logic [15:0] seq [5];
    logic [31:0] exp_e [3];
    seq = '{16'h0001, 16'h0001, 16'h0002, 16'h0002, 16'h0003};
    exp_e = '{{16'd0, 16'h0001}, {16'd2, 16'h0002}, {16'd4, 16'h0003}};
    do_reset();
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      probe = seq[i];
      tick();
    end
    en = 1'b0;
    total++; if (count !== 5'd3) begin bad++; $display("FAIL change_count got=%0d exp=3", count); end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (rd_data !== exp_e[i]) begin bad++; $display("FAIL change_entry%0d got=%h exp=%h", i, rd_data, exp_e[i]); end
      tick();
    end
    rd_ready = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL change_drained got=%0b exp=0", rd_valid); end
    $display("test_change done");
  endtask

  task automatic test_overflow();
    do_reset();
    en = 1'b1; mode = 1'b1; strobe = 1'b1; probe = 16'hABCD;
    for (int i = 0; i < 20; i++) tick();
    total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    total++; if (drop_cnt !== 8'd4) begin bad++; $display("FAIL ovf_drop got=%0d exp=4", drop_cnt); end
    $display("test_overflow done: count=%0d drop=%0d", count, drop_cnt);
  endtask

  task automatic test_back_to_back();
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++; if (rd_data !== {i[15:0], 16'hABCD}) begin bad++; $display("FAIL b2b_entry%0d got=%h exp=%h", i, rd_data, {i[15:0], 16'hABCD}); end
      tick();
      total++; if (count !== 5'd16) begin bad++; $display("FAIL b2b_count%0d got=%0d exp=16", i, count); end
    end
    total++; if (drop_cnt !== 8'd4) begin bad++; $display("FAIL b2b_drop got=%0d exp=4", drop_cnt); end
    total++; if (rd_data !== {16'd10, 16'hABCD}) begin bad++; $display("FAIL b2b_head got=%h exp=000aabcd", rd_data); end
    $display("test_back_to_back done");
  endtask

  task automatic test_clear();
    en = 1'b0; strobe = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    rd_ready = 1'b0;
    total++; if (count !== 5'd7) begin bad++; $display("FAIL clr_pre_count got=%0d exp=7", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr_pre_ovf got=%0b exp=1", overflow); end
    clear = 1'b1; en = 1'b1; mode = 1'b0; probe = 16'h5555;
    tick();
    clear = 1'b0; en = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL clr_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%0b exp=0", overflow); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL clr_drop got=%0d exp=0", drop_cnt); end
    tick();
    en = 1'b1;
    tick();
    en = 1'b0;
    total++; if (count !== 5'd1) begin bad++; $display("FAIL clr_recap_count got=%0d exp=1", count); end
    total++; if (rd_data !== {16'd1, 16'h5555}) begin bad++; $display("FAIL clr_recap_data got=%h exp=00015555", rd_data); end
    $display("test_clear done");
  endtask

  task automatic test_ts_wrap();
    do_reset();
    en = 1'b1; mode = 1'b1; strobe = 1'b1; rd_ready = 1'b1; probe = 16'h0042;
    for (int k = 1; k <= 20; k++) begin
      tick();
      total++; if (rd_data4 !== {4'((k - 1) % 16), 16'h0042}) begin bad++; $display("FAIL wrap_entry%0d got=%h exp=%h", k, rd_data4, {4'((k - 1) % 16), 16'h0042}); end
    end
    total++; if (count4 !== 5'd1) begin bad++; $display("FAIL wrap_count got=%0d exp=1", count4); end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL pushpop_count got=%0d exp=1", count); end
    $display("test_ts_wrap done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1; mode = 1'b1; strobe = 1'b1; probe = 16'h7777;
    for (int i = 0; i < 5; i++) tick();
    total++; if (count !== 5'd5) begin bad++; $display("FAIL mid_pre_count got=%0d exp=5", count); end
    reset = 1'b1;
    #1;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rd_valid got=%0b exp=0", rd_valid); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL mid_rd_data got=%h exp=0", rd_data); end
    tick();
    reset = 1'b0; en = 1'b0; strobe = 1'b0;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_hold();
    test_change();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_ts_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
